// File: rtl/dds_freq_meter.sv
// Frequency meter for the DDS sine path: detects rising midpoint crossings with
// hysteresis, counts samples over 2^AVG_LOG2 periods and divides to recover the FCW.
module dds_freq_meter #(
    parameter int unsigned HYST     = 256,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned CW       = 24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    output logic [31:0] fcw_out,
    output logic        fcw_valid,
    output logic        locked,
    output logic        busy
);

    localparam int unsigned NPER = 1 << AVG_LOG2;
    localparam int unsigned RW   = CW + 1;
    localparam int unsigned PW   = AVG_LOG2 + 1;
    localparam logic [15:0] LO_TH   = 16'(32'd32768 - HYST);
    localparam logic [15:0] HI_TH   = 16'(32'd32768 + HYST);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        COUNT = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            armed;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   per;
    logic [RW-1:0]   d_reg;
    logic [RW-1:0]   r_reg;
    logic [31:0]     q_reg;
    logic [4:0]      idx;
    logic            sat;

    logic            crossing_c;
    logic            arm_c;
    logic            last_per_c;
    logic            timeout_c;
    logic [RW-1:0]   d_c;
    logic [RW:0]     r2_c;
    logic            ge_c;
    logic [RW-1:0]   r_nx_c;

    logic [31:0]     fcw_nx;
    logic            valid_nx;
    logic            locked_nx;
    logic            busy_nx;

    // Crossing / arm / timeout qualification on the current sample
    always_comb begin
        crossing_c = sample_valid && armed && (sample >= HI_TH);
        arm_c      = sample_valid && (sample <= LO_TH);
        last_per_c = (per == PW'(NPER - 1));
        timeout_c  = sample_valid && !crossing_c && (cnt == CNT_MAX) &&
                     ((state == SYNC) || (state == COUNT));
        d_c        = RW'(cnt) + RW'(1);
    end

    // One restoring long-division step
    always_comb begin
        r2_c   = {r_reg, 1'b0};
        ge_c   = (r2_c >= {1'b0, d_reg});
        r_nx_c = ge_c ? RW'(r2_c - {1'b0, d_reg}) : RW'(r2_c);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            SYNC: begin
                if (crossing_c) begin
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                if (crossing_c && last_per_c) begin
                    state_nx = DIV;
                end else if (timeout_c) begin
                    state_nx = SYNC;
                end
            end
            DIV: begin
                if (idx == 5'd0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = SYNC;
            end
            default: begin
                state_nx = SYNC;
            end
        endcase
    end

    // Output next-values; a timeout result lands on the timing edge itself
    always_comb begin
        fcw_nx    = fcw_out;
        valid_nx  = 1'b0;
        locked_nx = locked;
        if (timeout_c) begin
            fcw_nx    = 32'd0;
            valid_nx  = 1'b1;
            locked_nx = 1'b0;
        end
        if (state == DONE) begin
            fcw_nx    = sat ? 32'hFFFF_FFFF : q_reg;
            valid_nx  = 1'b1;
            locked_nx = 1'b1;
        end
        busy_nx = (state_nx == DIV) || (state_nx == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fcw_out   <= 32'd0;
            fcw_valid <= 1'b0;
            locked    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fcw_out   <= fcw_nx;
            fcw_valid <= valid_nx;
            locked    <= locked_nx;
            busy      <= busy_nx;
        end
    end

    // Arm tracking, sample counting and divider datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            armed <= 1'b0;
            cnt   <= '0;
            per   <= '0;
            d_reg <= '0;
            r_reg <= '0;
            q_reg <= 32'd0;
            idx   <= 5'd0;
            sat   <= 1'b0;
        end else begin
            if (crossing_c) begin
                armed <= 1'b0;
            end else if (arm_c) begin
                armed <= 1'b1;
            end

            case (state)
                SYNC: begin
                    if (crossing_c) begin
                        cnt <= '0;
                        per <= '0;
                    end else if (timeout_c) begin
                        cnt <= '0;
                    end else if (sample_valid) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                COUNT: begin
                    if (timeout_c) begin
                        cnt <= '0;
                    end else if (sample_valid) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (crossing_c) begin
                        per <= per + PW'(1);
                        if (last_per_c) begin
                            d_reg <= d_c;
                            r_reg <= RW'(NPER);
                            q_reg <= 32'd0;
                            idx   <= 5'd31;
                            sat   <= (d_c <= RW'(NPER));
                        end
                    end
                end
                DIV: begin
                    r_reg      <= r_nx_c;
                    q_reg[idx] <= ge_c;
                    idx        <= idx - 5'd1;
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter: default instance plus a CW=12 instance for timeouts.
module tb_dds_freq_meter;

    logic        CLK;
    logic        RST;
    logic [15:0] sample;
    logic        sample_valid;

    logic [31:0] fcw_out;
    logic        fcw_valid;
    logic        locked;
    logic        busy;

    logic [31:0] to_fcw_out;
    logic        to_fcw_valid;
    logic        to_locked;
    logic        to_busy;

    int total;
    int bad;

    int          a_cnt, a_first, a_last;
    logic [31:0] a_fcw_first, a_fcw_last;
    logic        a_lock_first;
    int          b_cnt, b_first, b_last;
    logic [31:0] b_fcw_last;
    logic        b_lock_last;

    dds_freq_meter dut (
        .CLK          (CLK),
        .RST          (RST),
        .sample       (sample),
        .sample_valid (sample_valid),
        .fcw_out      (fcw_out),
        .fcw_valid    (fcw_valid),
        .locked       (locked),
        .busy         (busy)
    );

    dds_freq_meter #(.CW(12)) dut_to (
        .CLK          (CLK),
        .RST          (RST),
        .sample       (sample),
        .sample_valid (sample_valid),
        .fcw_out      (to_fcw_out),
        .fcw_valid    (to_fcw_valid),
        .locked       (to_locked),
        .busy         (to_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // 0 constant mid, 1 alternating, 2 triangle DDS (fcw 0x01000000), 3 square p100, 4 noisy square p100
    function automatic logic [15:0] gen(input int mode, input int k);
        logic [7:0]  p;
        int          m;
        logic [15:0] s;
        p = 8'(k);
        m = k % 100;
        s = 16'h8000;
        case (mode)
            1: s = (k % 2 == 0) ? 16'h0000 : 16'hFFFF;
            2: s = (p < 8'd128) ? (16'(p) << 9) : (16'(8'd255 - p) << 9);
            3: s = (m < 50) ? 16'h0000 : 16'hFFFF;
            4: begin
                if (m < 20 || (m >= 50 && m < 70))
                    s = (k % 2 == 0) ? 16'h8064 : 16'h7F9C;
                else if (m < 50)
                    s = 16'h0000;
                else
                    s = 16'hFFFF;
            end
            default: s = 16'h8000;
        endcase
        return s;
    endfunction

    task automatic run(input int mode, input int n);
        a_cnt = 0; a_first = -1; a_last = -1; a_fcw_first = '0; a_fcw_last = '0; a_lock_first = 1'b0;
        b_cnt = 0; b_first = -1; b_last = -1; b_fcw_last = '0; b_lock_last = 1'b0;
        for (int k = 0; k < n; k++) begin
            sample       = gen(mode, k);
            sample_valid = 1'b1;
            @(posedge CLK);
            #1;
            if (fcw_valid) begin
                if (a_cnt == 0) begin
                    a_first      = k;
                    a_fcw_first  = fcw_out;
                    a_lock_first = locked;
                end
                a_last     = k;
                a_fcw_last = fcw_out;
                a_cnt++;
            end
            if (to_fcw_valid) begin
                if (b_cnt == 0) b_first = k;
                b_last      = k;
                b_fcw_last  = to_fcw_out;
                b_lock_last = to_locked;
                b_cnt++;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        RST          = 1'b1;
        sample_valid = 1'b0;
        sample       = 16'h8000;
        repeat (cycles) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        CLK = 1'b0;
        total = 0;
        bad = 0;
        do_reset(2);
        chk("reset_fcw_out", fcw_out, 32'd0);
        chk("reset_fcw_valid", 32'(fcw_valid), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Constant midpoint: timeout every 4096 samples on the CW=12 instance
        run(0, 8200);
        chk("to_count", 32'(b_cnt), 32'd2);
        chk("to_first_idx", 32'(b_first), 32'd4095);
        chk("to_second_idx", 32'(b_last), 32'd8191);
        chk("to_fcw", b_fcw_last, 32'd0);
        chk("to_locked", 32'(b_lock_last), 32'd0);
        chk("no_to_cw24", 32'(a_cnt), 32'd0);

        // Alternating period 2: D=8, then timeout drops lock
        do_reset(1);
        run(1, 60);
        chk("alt_idx", 32'(a_first), 32'd42);
        chk("alt_fcw", a_fcw_first, 32'h8000_0000);
        chk("alt_locked", 32'(a_lock_first), 32'd1);
        chk("alt_to_locked_before", 32'(to_locked), 32'd1);
        run(0, 4400);
        chk("relock_to_count", 32'(b_cnt), 32'd2);
        chk("relock_first_idx", 32'(b_first), 32'd24);
        chk("relock_to_idx", 32'(b_last), 32'd4120);
        chk("relock_to_fcw", b_fcw_last, 32'd0);
        chk("relock_to_locked", 32'(b_lock_last), 32'd0);

        // DDS loop-back at fcw 0x01000000 (period 256)
        do_reset(1);
        run(2, 1200);
        chk("dds_count", 32'(a_cnt), 32'd1);
        chk("dds_idx", 32'(a_first), 32'd1122);
        chk("dds_fcw", a_fcw_first, 32'h0100_0000);
        chk("dds_locked", 32'(a_lock_first), 32'd1);

        // Square wave period 100: D=400 on every result
        do_reset(1);
        run(3, 1000);
        chk("sq_count", 32'(a_cnt), 32'd2);
        chk("sq_first_idx", 32'(a_first), 32'd483);
        chk("sq_first_fcw", a_fcw_first, 32'h028F_5C28);
        chk("sq_last_idx", 32'(a_last), 32'd983);
        chk("sq_last_fcw", a_fcw_last, 32'h028F_5C28);

        // Midpoint noise inside the hysteresis band
        do_reset(1);
        run(4, 520);
        chk("noise_count", 32'(a_cnt), 32'd1);
        chk("noise_idx", 32'(a_first), 32'd503);
        chk("noise_fcw", a_fcw_first, 32'h028F_5C28);

        // Reset on DIV cycle 10 of the second measurement
        do_reset(1);
        run(3, 960);
        chk("abort_pre_fcw", fcw_out, 32'h028F_5C28);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        do_reset(1);
        chk("abort_fcw_out", fcw_out, 32'd0);
        chk("abort_fcw_valid", 32'(fcw_valid), 32'd0);
        chk("abort_locked", 32'(locked), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        run(3, 500);
        chk("abort_next_count", 32'(a_cnt), 32'd1);
        chk("abort_next_idx", 32'(a_first), 32'd483);
        chk("abort_next_fcw", a_fcw_first, 32'h028F_5C28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
